multi_timer: RTL and testbench

Memory-mapped, parametrised multi-channel countdown timer for the MIPS SoC bus. It is the next-generation replacement for the single-channel device timer. It provides CHANNELS independent timers, each with a configurable counter width, clock prescaler and one-shot or periodic mode. Interrupts are sticky and write-1-to-clear, and all channels combine onto one `irq` line for the CP0 interrupt input.

---
 rtl/multi_timer_pkg.sv | 31 +++
 rtl/multi_timer_channel.sv | 97 +++++++++
 rtl/multi_timer.sv | 89 ++++++++
 tb/tb_multi_timer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_timer_pkg.sv
// Shared encodings for the multi-channel countdown timer.
// Register map offsets, CTRL bit positions and FSM/mode codes.
package multi_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COUNT  = 2'd2,
    ST_EXPIRE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_RSVD2    = 2'd2,
    MODE_RSVD3    = 2'd3
  } mode_e;

  localparam logic [31:0] OFF_CTRL     = 32'h00;
  localparam logic [31:0] OFF_PRESET   = 32'h04;
  localparam logic [31:0] OFF_COUNT    = 32'h08;
  localparam logic [31:0] OFF_PRESCALE = 32'h0c;
  localparam logic [31:0] OFF_STRIDE   = 32'h10;
  localparam logic [31:0] OFF_STATUS   = 32'h80;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IRQ     = 3;

endpackage

// File: rtl/multi_timer_channel.sv
// One countdown channel: CTRL/PRESET/PRESCALE registers plus FSM.
// A bus write to this channel freezes the FSM for that cycle.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int PRESCALE_BITS = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [3:0]               i_wr_off,
  input  logic [31:0]              i_wr_data,
  output logic [3:0]               o_ctrl,
  output logic [WIDTH-1:0]         o_preset,
  output logic [WIDTH-1:0]         o_count,
  output logic [PRESCALE_BITS-1:0] o_prescale,
  output logic                     o_expire
);

  state_e                   r_state;
  logic                     r_enable;
  logic [1:0]               r_mode;
  logic                     r_allow;
  logic [WIDTH-1:0]         r_preset;
  logic [WIDTH-1:0]         r_count;
  logic [PRESCALE_BITS-1:0] r_prescale;
  logic [PRESCALE_BITS-1:0] r_psc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_enable   <= 1'b0;
      r_mode     <= 2'b00;
      r_allow    <= 1'b0;
      r_preset   <= '0;
      r_count    <= '0;
      r_prescale <= '0;
      r_psc      <= '0;
    end else if (i_wr_en) begin
      case (i_wr_off)
        OFF_CTRL[3:0]: begin
          r_enable <= i_wr_data[CTRL_EN];
          r_mode   <= i_wr_data[CTRL_MODE_HI:CTRL_MODE_LO];
          r_allow  <= i_wr_data[CTRL_IRQ];
        end
        OFF_PRESET[3:0]:   r_preset   <= i_wr_data[WIDTH-1:0];
        OFF_PRESCALE[3:0]: r_prescale <= i_wr_data[PRESCALE_BITS-1:0];
        default: ;
      endcase
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (r_enable) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_count <= r_preset;
          r_psc   <= '0;
          r_state <= ST_COUNT;
        end
        ST_COUNT: begin
          if (!r_enable) begin
            r_state <= ST_IDLE;
          end else if (r_count == '0) begin
            r_state <= ST_EXPIRE;
          end else if (r_psc == r_prescale) begin
            r_psc <= '0;
            if (r_count == WIDTH'(1)) begin
              r_count <= '0;
              r_state <= ST_EXPIRE;
            end else begin
              r_count <= r_count - WIDTH'(1);
            end
          end else begin
            r_psc <= r_psc + PRESCALE_BITS'(1);
          end
        end
        ST_EXPIRE: begin
          if (r_mode == MODE_PERIODIC) begin
            r_state <= ST_LOAD;
          end else begin
            r_enable <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Pending is raised only on the cycle EXPIRE actually retires.
  assign o_expire   = (r_state == ST_EXPIRE) && !i_wr_en && r_allow;
  assign o_ctrl     = {r_allow, r_mode, r_enable};
  assign o_preset   = r_preset;
  assign o_count    = r_count;
  assign o_prescale = r_prescale;

endmodule

// File: rtl/multi_timer.sv
// Bus-mapped multi-channel timer: decode, read mux, W1C pending, irq.
// Channel n lives at BASE+16n, STATUS at BASE+0x80.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter logic [31:0] BASE          = 32'h0000_7f00,
  parameter int          CHANNELS      = 2,
  parameter int          WIDTH         = 32,
  parameter int          PRESCALE_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_result,
  output logic        irq
);

  localparam logic [31:0] MAP_END = 32'(CHANNELS) * OFF_STRIDE;

  logic [31:0]              w_off;
  logic                     w_aligned;
  logic                     w_in_ch;
  logic                     w_status;
  logic [CHANNELS-1:0]      w_sel;
  logic [CHANNELS-1:0]      w_wr;
  logic [CHANNELS-1:0]      w_expire;
  logic [CHANNELS-1:0]      w_clr;
  logic [CHANNELS-1:0]      r_pending;
  logic [3:0]               w_ctrl     [CHANNELS];
  logic [WIDTH-1:0]         w_preset   [CHANNELS];
  logic [WIDTH-1:0]         w_count    [CHANNELS];
  logic [PRESCALE_BITS-1:0] w_prescale [CHANNELS];

  assign w_off     = addr - BASE;
  assign w_aligned = (w_off[1:0] == 2'b00);
  assign w_in_ch   = w_aligned && (w_off < MAP_END);
  assign w_status  = (w_off == OFF_STATUS);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign w_sel[g] = w_in_ch && (w_off[6:4] == 3'(g));
    assign w_wr[g]  = write_enable && w_sel[g];

    timer_channel #(
      .WIDTH         (WIDTH),
      .PRESCALE_BITS (PRESCALE_BITS)
    ) u_ch (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_wr_en    (w_wr[g]),
      .i_wr_off   (w_off[3:0]),
      .i_wr_data  (write_data),
      .o_ctrl     (w_ctrl[g]),
      .o_preset   (w_preset[g]),
      .o_count    (w_count[g]),
      .o_prescale (w_prescale[g]),
      .o_expire   (w_expire[g])
    );
  end

  assign w_clr = (write_enable && w_status) ?
                 write_data[CHANNELS-1:0] : '0;

  // A fresh expiry beats a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else     r_pending <= (r_pending & ~w_clr) | w_expire;
  end

  assign irq = |r_pending;

  always_comb begin
    read_result = '0;
    if (w_status) read_result = 32'(r_pending);
    for (int n = 0; n < CHANNELS; n++) begin
      if (w_sel[n]) begin
        case (w_off[3:0])
          OFF_CTRL[3:0]:     read_result = 32'(w_ctrl[n]);
          OFF_PRESET[3:0]:   read_result = 32'(w_preset[n]);
          OFF_COUNT[3:0]:    read_result = 32'(w_count[n]);
          OFF_PRESCALE[3:0]: read_result = 32'(w_prescale[n]);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: directed scenarios plus random bus traffic,
// checked each cycle against an elapsed-time reference model.
module tb_multi_timer;

  localparam logic [31:0] BASE = 32'h0000_7f00;
  localparam int          NCH  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_result;
  logic        irq;

  always #5 clk = ~clk;

  multi_timer #(
    .BASE          (BASE),
    .CHANNELS      (NCH),
    .WIDTH         (32),
    .PRESCALE_BITS (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_result  (read_result),
    .irq          (irq)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference: a run is tracked by the number of unstalled edges
  // since it began (1 = loading, 2.. = counting, 2+D = expiring).
  bit          m_en    [NCH];
  logic [1:0]  m_mode  [NCH];
  bit          m_allow [NCH];
  logic [31:0] m_preset[NCH];
  logic [7:0]  m_psc   [NCH];
  logic [31:0] m_count [NCH];
  bit          m_run   [NCH];
  int          m_e     [NCH];
  logic [31:0] m_rp    [NCH];
  logic [1:0]  m_pend;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int dur(int n);
    if (m_rp[n] == 0) return 1;
    return int'(m_rp[n]) * (int'(m_psc[n]) + 1);
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NCH; n++) begin
      m_en[n] = 0; m_mode[n] = 0; m_allow[n] = 0;
      m_preset[n] = 0; m_psc[n] = 0; m_count[n] = 0;
      m_run[n] = 0; m_e[n] = 0; m_rp[n] = 0;
    end
    m_pend = 0;
  endtask

  task automatic model_edge(input bit r, input bit we,
                            input logic [31:0] a,
                            input logic [31:0] d);
    logic [31:0] off;
    logic [1:0]  set, clr;
    int wch, wreg, j;
    if (r) begin
      model_reset();
      return;
    end
    off = a - BASE;
    wch = -1; wreg = 0; set = 0; clr = 0;
    if (we && off[1:0] == 2'b00 && off < 32'(NCH * 16)) begin
      wch  = int'(off >> 4);
      wreg = int'(off[3:0]);
    end
    if (we && off == 32'h80) clr = d[1:0];
    for (int n = 0; n < NCH; n++) begin
      if (n == wch) begin
        case (wreg)
          0:  begin
                m_en[n] = d[0]; m_mode[n] = d[2:1];
                m_allow[n] = d[3];
              end
          4:  m_preset[n] = d;
          12: m_psc[n] = d[7:0];
          default: ;
        endcase
      end else if (!m_run[n]) begin
        if (m_en[n]) begin
          m_run[n] = 1; m_e[n] = 1;
        end
      end else if (m_e[n] == 1) begin
        m_rp[n] = m_preset[n]; m_count[n] = m_rp[n]; m_e[n] = 2;
      end else if (m_e[n] - 2 < dur(n)) begin
        if (!m_en[n]) begin
          m_run[n] = 0;
        end else begin
          m_e[n]++;
          j = m_e[n] - 2;
          m_count[n] = (m_rp[n] == 0) ? 32'd0 :
            m_rp[n] - 32'(j / (int'(m_psc[n]) + 1));
        end
      end else begin
        if (m_allow[n]) set[n] = 1'b1;
        if (m_mode[n] == 2'b01) m_e[n] = 1;
        else begin m_en[n] = 0; m_run[n] = 0; end
      end
    end
    m_pend = (m_pend & ~clr) | set;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = read_result;
  endtask

  task automatic check_all();
    logic [31:0] v;
    for (int n = 0; n < NCH; n++) begin
      rd(BASE + 32'(16 * n) + 8, v);
      check($sformatf("count%0d", n), v, m_count[n]);
      rd(BASE + 32'(16 * n), v);
      check($sformatf("ctrl%0d", n), v,
            {28'd0, m_allow[n], m_mode[n], m_en[n]});
    end
    rd(BASE + 32'h80, v);
    check("status", v, {30'd0, m_pend});
    check("irq", {31'd0, irq}, {31'd0, |m_pend});
  endtask

  task automatic step(input bit r, input bit we,
                      input logic [31:0] a, input logic [31:0] d);
    rst = r; write_enable = we; addr = a; write_data = d;
    @(posedge clk);
    model_edge(r, we, a, d);
    cyc++;
    #1;
    rst = 1'b0; write_enable = 1'b0;
    check_all();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, BASE, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(0, 1, a, d);
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] v;
    for (int o = 0; o < 32; o += 4) begin
      rd(BASE + 32'(o), v);
      check($sformatf("%s_off%0d", tag, o), v, 32'd0);
    end
    rd(BASE + 32'h80, v);
    check({tag, "_status"}, v, 32'd0);
    check({tag, "_irq"}, {31'd0, irq}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int c1, c2, r, ch, sel;

    rst = 1'b1; write_enable = 1'b0; addr = BASE; write_data = 0;
    model_reset();
    step(1, 0, BASE, 0);
    step(1, 0, BASE, 0);
    check_all_zero("reset");

    // One-shot, preset 5, prescale 0: irq exactly at t+8
    wr(BASE + 4, 5);
    wr(BASE + 12, 0);
    wr(BASE + 0, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      if (k == 7) check("oneshot_irq_t7", {31'd0, irq}, 32'd0);
      if (k == 8) check("oneshot_irq_t8", {31'd0, irq}, 32'd1);
    end
    rd(BASE, v);
    check("oneshot_ctrl", v, 32'h8);
    rd(BASE + 32'h80, v);
    check("oneshot_status", v, 32'h1);
    wr(BASE + 32'h80, 32'h1);
    check("oneshot_w1c", {31'd0, irq}, 32'd0);

    // Periodic ch1, preset 3, prescale 1: one pending every 8 cycles
    wr(BASE + 16 + 4, 3);
    wr(BASE + 16 + 12, 1);
    wr(BASE + 16, 32'hB);
    for (int i = 0; i < 40 && !irq; i++) idle(1);
    check("per_first", {31'd0, irq}, 32'd1);
    c1 = cyc;
    wr(BASE + 32'h80, 32'h2);
    check("per_w1c", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 40 && !irq; i++) idle(1);
    check("per_second", {31'd0, irq}, 32'd1);
    c2 = cyc;
    check("per_interval", 32'(c2 - c1), 32'd8);

    // ch0 hammered by writes; ch1 period must be unaffected
    wr(BASE + 32'h80, 32'h2);
    for (int i = 0; i < 6; i++) wr(BASE + 12, 0);
    check("stall_early", {31'd0, irq}, 32'd0);
    wr(BASE + 12, 0);
    check("stall_ontime", {31'd0, irq}, 32'd1);
    wr(BASE + 32'h80, 32'h2);
    check("stall_w1c", {31'd0, irq}, 32'd0);
    idle(6);
    wr(BASE + 32'h80, 32'h2);
    rd(BASE + 32'h80, v);
    check("set_beats_w1c", v, 32'h2);

    wr(BASE + 16, 0);
    idle(5);
    wr(BASE + 32'h80, 32'h3);
    idle(2);
    check("ch1_off_irq", {31'd0, irq}, 32'd0);

    // Preset 0: pending four edges after the enable write
    wr(BASE + 4, 0);
    wr(BASE + 0, 32'h9);
    idle(3);
    check("p0_irq_t3", {31'd0, irq}, 32'd0);
    idle(1);
    check("p0_irq_t4", {31'd0, irq}, 32'd1);
    wr(BASE + 32'h80, 32'h1);
    wr(BASE + 0, 32'h1);
    idle(6);
    rd(BASE, v);
    check("noirq_ctrl", v, 32'h0);
    check("noirq_irq", {31'd0, irq}, 32'd0);

    // Disable at COUNT=7, re-enable reloads, late PRESET ignored
    wr(BASE + 4, 10);
    wr(BASE + 0, 32'h1);
    idle(5);
    rd(BASE + 8, v);
    check("mid_count7", v, 32'd7);
    wr(BASE + 0, 32'h0);
    idle(3);
    rd(BASE + 8, v);
    check("hold_count7", v, 32'd7);
    wr(BASE + 0, 32'h1);
    idle(2);
    rd(BASE + 8, v);
    check("reload_10", v, 32'd10);
    wr(BASE + 4, 3);
    idle(1);
    rd(BASE + 8, v);
    check("preset_no_effect", v, 32'd9);
    idle(12);
    rd(BASE + 8, v);
    check("run_done_count", v, 32'd0);

    // Reset mid-count on both channels, with a concurrent write
    wr(BASE + 4, 20);
    wr(BASE + 0, 32'h9);
    wr(BASE + 16 + 4, 20);
    wr(BASE + 16 + 12, 2);
    wr(BASE + 16, 32'hB);
    idle(6);
    step(1, 1, BASE + 4, 32'd99);
    check_all_zero("midrst");

    // Out-of-map and unaligned accesses
    wr(BASE + 1, 32'hF);
    rd(BASE + 32'h40, v);
    check("rd_0x40", v, 32'd0);
    rd(BASE + 32'h84, v);
    check("rd_0x84", v, 32'd0);
    rd(BASE + 1, v);
    check("rd_unal1", v, 32'd0);
    rd(BASE + 6, v);
    check("rd_unal6", v, 32'd0);
    rd(BASE - 4, v);
    check("rd_below", v, 32'd0);
    rd(BASE, v);
    check("unal_wr_ignored", v, 32'd0);

    // Random traffic against the reference model
    for (int it = 0; it < 1500; it++) begin
      r   = int'($urandom_range(0, 99));
      ch  = int'($urandom_range(0, NCH - 1));
      sel = int'($urandom_range(0, 3));
      if (r < 55) begin
        idle(1);
      end else if (r < 70) begin
        case (sel)
          0: wr(BASE + 32'(16 * ch),
                {28'd0, m_allow[ch], m_mode[ch], m_en[ch]});
          1: wr(BASE + 32'(16 * ch) + 4, $urandom_range(0, 6));
          2: wr(BASE + 32'(16 * ch) + 8, $urandom);
          default: wr(BASE + 32'(16 * ch) + 12, {24'd0, m_psc[ch]});
        endcase
      end else if (r < 80) begin
        wr(BASE + 32'h80, $urandom_range(0, 3));
      end else if (r < 90) begin
        wr(BASE + 32'(16 * ch), $urandom_range(0, 15));
      end else if (!m_run[ch]) begin
        wr(BASE + 32'(16 * ch) + 12, $urandom_range(0, 3));
      end else begin
        wr(BASE + 32'(16 * ch) + 4, $urandom_range(0, 6));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
